// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard unit for the in-order pipeline.
// It tracks in-flight destinations in its own shift-register scoreboard, which starts at EX.
module fwd_hazard_unit #(
  parameter int ADDR_W   = 5,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   hold_i,
  input  logic                   flush_i,
  input  logic                   id_valid_i,
  input  logic [NSRC*ADDR_W-1:0] id_src_addr_i,
  input  logic [NSRC-1:0]        id_src_use_i,
  input  logic [ADDR_W-1:0]      id_dst_addr_i,
  input  logic                   id_wb_i,
  input  logic                   id_load_i,
  output logic                   stall_o,
  output logic                   ex_valid_o,
  output logic [NSRC*SEL_W-1:0]  fwd_sel_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  logic [DEPTH-1:0]             sb_valid;
  logic [DEPTH-1:0]             sb_wb;
  logic [DEPTH-1:0]             sb_load;
  logic [DEPTH-1:0][ADDR_W-1:0] sb_dst;

  logic [NSRC*SEL_W-1:0] sel_next;
  logic [NSRC-1:0]       hazard;
  logic [ADDR_W-1:0]     src;
  logic                  issue;

  // Scan from oldest to youngest, so the lowest matching entry overwrites any older match.
  always_comb begin
    sel_next = '0;
    hazard   = '0;
    src      = '0;
    for (int s = 0; s < NSRC; s++) begin
      src = id_src_addr_i[s*ADDR_W +: ADDR_W];
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (id_src_use_i[s] && (src != '0) && sb_valid[j] && sb_wb[j] &&
            (sb_dst[j] == src)) begin
          sel_next[s*SEL_W +: SEL_W] = SEL_W'(j + 1);
          hazard[s] = sb_load[j] && (j < LOAD_LAT);
        end
      end
    end
  end

  assign stall_o = id_valid_i && !flush_i && (|hazard);
  assign issue   = id_valid_i && !flush_i && !stall_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sb_valid    <= '0;
      sb_wb       <= '0;
      sb_load     <= '0;
      sb_dst      <= '0;
      ex_valid_o  <= 1'b0;
      fwd_sel_o   <= '0;
      stall_cnt_o <= '0;
    end else if (!hold_i) begin
      for (int j = 1; j < DEPTH; j++) begin
        sb_valid[j] <= sb_valid[j-1];
        sb_wb[j]    <= sb_wb[j-1];
        sb_load[j]  <= sb_load[j-1];
        sb_dst[j]   <= sb_dst[j-1];
      end
      // A stalled or flushed slot enters EX as a bubble.
      sb_valid[0] <= issue;
      sb_wb[0]    <= issue && id_wb_i;
      sb_load[0]  <= issue && id_load_i;
      sb_dst[0]   <= issue ? id_dst_addr_i : '0;
      ex_valid_o  <= issue;
      fwd_sel_o   <= issue ? sel_next : '0;
      if (stall_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: one default instance and one with DEPTH=3, LOAD_LAT=2, CNT_W=2.
// Both instances share the stimulus, and each section checks only the instance it targets.
module tb_fwd_hazard_unit;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       hold_i;
  logic       flush_i;
  logic       id_valid_i;
  logic [9:0] id_src_addr_i;
  logic [1:0] id_src_use_i;
  logic [4:0] id_dst_addr_i;
  logic       id_wb_i;
  logic       id_load_i;

  logic        stall_a, exv_a;
  logic [3:0]  sel_a;
  logic [15:0] cnt_a;
  logic        stall_b, exv_b;
  logic [3:0]  sel_b;
  logic [1:0]  cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_unit dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_src_addr_i(id_src_addr_i), .id_src_use_i(id_src_use_i),
    .id_dst_addr_i(id_dst_addr_i), .id_wb_i(id_wb_i), .id_load_i(id_load_i),
    .stall_o(stall_a), .ex_valid_o(exv_a), .fwd_sel_o(sel_a), .stall_cnt_o(cnt_a)
  );

  fwd_hazard_unit #(.DEPTH(3), .LOAD_LAT(2), .CNT_W(2)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_src_addr_i(id_src_addr_i), .id_src_use_i(id_src_use_i),
    .id_dst_addr_i(id_dst_addr_i), .id_wb_i(id_wb_i), .id_load_i(id_load_i),
    .stall_o(stall_b), .ex_valid_o(exv_b), .fwd_sel_o(sel_b), .stall_cnt_o(cnt_b)
  );

  task automatic apply_stimulus(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                                input logic [1:0] use_mask, input logic [4:0] dst,
                                input logic wb, input logic ld);
    id_valid_i    = v;
    id_src_addr_i = {s1, s0};
    id_src_use_i  = use_mask;
    id_dst_addr_i = dst;
    id_wb_i       = wb;
    id_load_i     = ld;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i   = 1'b0;
    hold_i  = 1'b0;
    flush_i = 1'b0;
    apply_stimulus(0, 0, 0, 2'b00, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    check_output("rst_stall", stall_a, 0);
    check_output("rst_exv", exv_a, 0);
    check_output("rst_sel", sel_a, 0);
    check_output("rst_cnt", cnt_a, 0);

    // ALU RAW: producer r3, then src0 at distance 1, then src1 at distance 2
    apply_stimulus(1, 0, 0, 2'b00, 3, 1, 0);
    #1 check_output("raw_prod_stall", stall_a, 0);
    tick();
    check_output("raw_prod_exv", exv_a, 1);
    check_output("raw_prod_sel", sel_a, 0);
    apply_stimulus(1, 3, 0, 2'b01, 7, 1, 0);
    tick();
    check_output("raw_c1_exv", exv_a, 1);
    check_output("raw_c1_sel", sel_a, 4'b0001);
    apply_stimulus(1, 0, 3, 2'b10, 9, 1, 0);
    #1 check_output("raw_c2_stall", stall_a, 0);
    tick();
    check_output("raw_c2_sel", sel_a, 4'b1000);

    // youngest-wins and distances
    apply_stimulus(1, 0, 0, 2'b00, 4, 1, 0);
    tick();
    tick();
    apply_stimulus(1, 4, 0, 2'b01, 20, 1, 0);
    tick();
    check_output("yw_twice_sel", sel_a, 1);
    apply_stimulus(1, 0, 0, 2'b00, 10, 1, 0);
    tick();
    apply_stimulus(0, 0, 0, 2'b00, 0, 0, 0);
    tick();
    check_output("nop_exv", exv_a, 0);
    check_output("nop_sel", sel_a, 0);
    apply_stimulus(1, 10, 0, 2'b01, 21, 1, 0);
    tick();
    check_output("yw_gap1_sel", sel_a, 2);
    apply_stimulus(1, 0, 0, 2'b00, 11, 1, 0);
    tick();
    apply_stimulus(0, 0, 0, 2'b00, 0, 0, 0);
    repeat (3) tick();
    apply_stimulus(1, 11, 11, 2'b11, 22, 1, 0);
    tick();
    check_output("yw_gap3_exv", exv_a, 1);
    check_output("yw_gap3_sel", sel_a, 0);
    apply_stimulus(1, 0, 0, 2'b00, 12, 1, 0);
    tick();
    apply_stimulus(1, 12, 12, 2'b11, 23, 1, 0);
    tick();
    check_output("both_src_sel", sel_a, 4'b0101);

    // load-use, one bubble
    apply_stimulus(1, 0, 0, 2'b00, 5, 1, 1);
    tick();
    check_output("lu_load_exv", exv_a, 1);
    apply_stimulus(1, 5, 0, 2'b01, 6, 1, 0);
    #1 check_output("lu_stall", stall_a, 1);
    tick();
    check_output("lu_bubble_exv", exv_a, 0);
    check_output("lu_bubble_cnt", cnt_a, 1);
    check_output("lu_release_stall", stall_a, 0);
    tick();
    check_output("lu_issue_exv", exv_a, 1);
    check_output("lu_issue_sel", sel_a, 2);
    check_output("lu_issue_cnt", cnt_a, 1);

    // filters: r0, no write-back, unused sources, flush
    apply_stimulus(1, 0, 0, 2'b00, 0, 1, 0);
    tick();
    apply_stimulus(1, 0, 0, 2'b01, 24, 1, 0);
    tick();
    check_output("r0_sel", sel_a, 0);
    apply_stimulus(1, 0, 0, 2'b00, 13, 0, 0);
    tick();
    apply_stimulus(1, 13, 0, 2'b01, 25, 1, 0);
    tick();
    check_output("nowb_sel", sel_a, 0);
    apply_stimulus(1, 0, 0, 2'b00, 14, 1, 1);
    tick();
    apply_stimulus(1, 14, 14, 2'b00, 26, 1, 0);
    #1 check_output("nouse_stall", stall_a, 0);
    tick();
    check_output("nouse_exv", exv_a, 1);
    check_output("nouse_sel", sel_a, 0);
    check_output("nouse_cnt", cnt_a, 1);
    apply_stimulus(1, 0, 0, 2'b00, 15, 1, 1);
    tick();
    apply_stimulus(1, 15, 0, 2'b01, 27, 1, 0);
    flush_i = 1'b1;
    #1 check_output("flush_stall", stall_a, 0);
    tick();
    check_output("flush_exv", exv_a, 0);
    check_output("flush_sel", sel_a, 0);
    check_output("flush_cnt", cnt_a, 1);
    flush_i = 1'b0;
    #1 check_output("post_flush_stall", stall_a, 0);
    tick();
    check_output("post_flush_sel", sel_a, 2);

    // hold during a load-use stall
    apply_stimulus(1, 0, 0, 2'b00, 16, 1, 1);
    tick();
    apply_stimulus(1, 16, 0, 2'b01, 28, 1, 0);
    #1 check_output("hold_pre_stall", stall_a, 1);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("hold_stall", stall_a, 1);
      check_output("hold_exv", exv_a, 1);
      check_output("hold_cnt", cnt_a, 1);
    end
    hold_i = 1'b0;
    tick();
    check_output("hold_rel_exv", exv_a, 0);
    check_output("hold_rel_cnt", cnt_a, 2);
    check_output("hold_rel_stall", stall_a, 0);
    tick();
    check_output("hold_issue_sel", sel_a, 2);
    check_output("hold_issue_exv", exv_a, 1);

    // async reset during a stall
    apply_stimulus(1, 0, 0, 2'b00, 17, 1, 1);
    tick();
    apply_stimulus(1, 17, 0, 2'b01, 29, 1, 0);
    #1 check_output("mid_pre_stall", stall_a, 1);
    #2 rst_i = 1'b0;
    #1;
    check_output("mid_rst_exv", exv_a, 0);
    check_output("mid_rst_sel", sel_a, 0);
    check_output("mid_rst_cnt", cnt_a, 0);
    check_output("mid_rst_stall", stall_a, 0);
    #1 rst_i = 1'b1;
    #1 check_output("after_rst_stall", stall_a, 0);
    tick();
    check_output("after_rst_exv", exv_a, 1);
    check_output("after_rst_sel", sel_a, 0);

    // second instance: LOAD_LAT=2, DEPTH=3, CNT_W=2
    rst_i = 1'b0;
    apply_stimulus(0, 0, 0, 2'b00, 0, 0, 0);
    #2 rst_i = 1'b1;
    #1;
    apply_stimulus(1, 0, 0, 2'b00, 5, 1, 1);
    tick();
    check_output("b_load_exv", exv_b, 1);
    apply_stimulus(1, 5, 0, 2'b01, 6, 1, 0);
    #1 check_output("b_stall1", stall_b, 1);
    tick();
    check_output("b_bubble1_exv", exv_b, 0);
    check_output("b_bubble1_cnt", cnt_b, 1);
    check_output("b_stall2", stall_b, 1);
    tick();
    check_output("b_bubble2_exv", exv_b, 0);
    check_output("b_bubble2_cnt", cnt_b, 2);
    check_output("b_release_stall", stall_b, 0);
    tick();
    check_output("b_issue_exv", exv_b, 1);
    check_output("b_issue_sel", sel_b, 3);
    check_output("b_issue_cnt", cnt_b, 2);

    // two more load-use pairs: six stall cycles in total, counter pinned at 3
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1, 0, 0, 2'b00, 5'(7 + k), 1, 1);
      tick();
      apply_stimulus(1, 5'(7 + k), 0, 2'b01, 30, 1, 0);
      #1 check_output("b_sat_stall", stall_b, 1);
      tick();
      tick();
      tick();
      check_output("b_sat_sel", sel_b, 3);
      check_output("b_sat_cnt", cnt_b, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
